// File: rtl/fpu_pkg.sv
// Shared constants, field widths and pipeline stage records for the
// normalize/round back end of the single-precision FMA datapath.
package fpu_pkg;

    localparam int BIAS     = 127;
    localparam int EXP_MAX  = 2 * BIAS + 1;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    localparam int RESULT_W  = 32;
    localparam int EXP_W     = 9;
    localparam int MANT_W    = 27;
    localparam int FRAC_W    = 23;
    localparam int ADJ_EXP_W = 10;
    localparam int LZC_IN_W  = 26;
    localparam int LZC_W     = 5;
    localparam int FLAG_W    = 4;

    localparam int ROUND_NEAREST_EVEN = 0;
    localparam int ROUND_TOWARD_ZERO  = 1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  expIn;
        logic [MANT_W-1:0] mant;
        logic [LZC_W-1:0]  lz;
        logic              carry;
        logic              zero;
        logic              inf;
        logic              invalid;
    } s1_t;

    // Mantissa is normalized here: [25] hidden, [24:2] fraction, [1] guard, [0] sticky
    typedef struct packed {
        logic                        sign;
        logic signed [ADJ_EXP_W-1:0] expAdj;
        logic [MANT_W-2:0]           mant;
        logic                        zero;
        logic                        inf;
        logic                        invalid;
    } s2_t;

    function automatic logic [RESULT_W-1:0] packFloat(
        input logic              sign,
        input logic [7:0]        expField,
        input logic [FRAC_W-1:0] frac
    );
        return {sign, expField, frac};
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input reports the full width.
module fpu_lzc
    import fpu_pkg::*;
(
    input  logic [LZC_IN_W-1:0] i_value,
    output logic [LZC_W-1:0]    o_count
);

    // Scan upward so the highest set bit is the last one to write the count
    always_comb begin
        o_count = LZC_W'(LZC_IN_W);
        for (int i = 0; i < LZC_IN_W; i++) begin
            if (i_value[i]) begin
                o_count = LZC_W'(LZC_IN_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpu_normalize_round.sv
// Three-stage normalize, round and pack pipeline for single-precision FMA
// results, with one global advance enable providing valid/ready backpressure.
module fpu_normalize_round
    import fpu_pkg::*;
#(
    parameter int ROUND_MODE = ROUND_NEAREST_EVEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [EXP_W-1:0]     in_exp,
    input  logic [MANT_W-1:0]    in_mantissa,
    input  logic                 in_infinite,
    input  logic                 in_invalid,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RESULT_W-1:0]  out_result,
    output logic [FLAG_W-1:0]    out_flags
);

    logic                        w_advance;
    logic [LZC_W-1:0]            w_lz;
    s2_t                         w_s2Next;
    logic                        w_guard;
    logic                        w_sticky;
    logic                        w_lsb;
    logic                        w_roundUp;
    logic [FRAC_W+1:0]           w_sum;
    logic [FRAC_W-1:0]           w_frac;
    logic signed [ADJ_EXP_W:0]   w_expFinal;
    logic [RESULT_W-1:0]         w_result;
    logic [FLAG_W-1:0]           w_flags;

    logic                        r_s1Valid;
    s1_t                         r_s1;
    logic                        r_s2Valid;
    s2_t                         r_s2;
    logic                        r_s3Valid;
    logic [RESULT_W-1:0]         r_result;
    logic [FLAG_W-1:0]           r_flags;

    // Masking with rst keeps out_valid low and in_ready high even before the first reset edge
    assign out_valid  = r_s3Valid & ~rst;
    assign w_advance  = out_ready | ~out_valid;
    assign in_ready   = w_advance;
    assign out_result = r_result;
    assign out_flags  = r_flags;

    fpu_lzc u_lzc (
        .i_value (in_mantissa[LZC_IN_W-1:0]),
        .o_count (w_lz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
        end else if (w_advance) begin
            r_s1Valid     <= in_valid;
            r_s1.sign     <= in_sign;
            r_s1.expIn    <= in_exp;
            r_s1.mant     <= in_mantissa;
            r_s1.lz       <= w_lz;
            r_s1.carry    <= in_mantissa[MANT_W-1];
            r_s1.zero     <= (in_mantissa == '0);
            r_s1.inf      <= in_infinite;
            r_s1.invalid  <= in_invalid;
        end
    end

    // The carry path saturates at the top exponent so 511 + 1 cannot wrap negative
    always_comb begin
        w_s2Next         = '0;
        w_s2Next.sign    = r_s1.sign;
        w_s2Next.zero    = r_s1.zero;
        w_s2Next.inf     = r_s1.inf;
        w_s2Next.invalid = r_s1.invalid;
        if (r_s1.carry) begin
            w_s2Next.mant   = {r_s1.mant[MANT_W-1:2], r_s1.mant[1] | r_s1.mant[0]};
            w_s2Next.expAdj = (r_s1.expIn == '1) ? 10'sd511
                                                 : signed'({1'b0, r_s1.expIn} + 10'd1);
        end else begin
            w_s2Next.mant   = r_s1.mant[MANT_W-2:0] << r_s1.lz;
            w_s2Next.expAdj = signed'({1'b0, r_s1.expIn}) - signed'({5'd0, r_s1.lz});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
        end else if (w_advance) begin
            r_s2Valid <= r_s1Valid;
            r_s2      <= w_s2Next;
        end
    end

    assign w_lsb      = r_s2.mant[2];
    assign w_guard    = r_s2.mant[1];
    assign w_sticky   = r_s2.mant[0];
    assign w_roundUp  = (ROUND_MODE == ROUND_TOWARD_ZERO) ? 1'b0
                                                          : (w_guard & (w_sticky | w_lsb));
    assign w_sum      = {1'b0, r_s2.mant[MANT_W-2:2]} + {{(FRAC_W+1){1'b0}}, w_roundUp};
    assign w_frac     = w_sum[FRAC_W+1] ? w_sum[FRAC_W:1] : w_sum[FRAC_W-1:0];
    assign w_expFinal = {r_s2.expAdj[ADJ_EXP_W-1], r_s2.expAdj}
                      + {{ADJ_EXP_W{1'b0}}, w_sum[FRAC_W+1]};

    // Flags are {invalid, overflow, underflow, inexact}; special cases override in priority order
    always_comb begin
        w_result = packFloat(r_s2.sign, w_expFinal[7:0], w_frac);
        w_flags  = {3'b000, w_guard | w_sticky};
        if (r_s2.invalid) begin
            w_result = QNAN;
            w_flags  = 4'b1000;
        end else if (r_s2.inf) begin
            w_result = packFloat(r_s2.sign, 8'hFF, '0);
            w_flags  = 4'b0000;
        end else if (r_s2.zero) begin
            w_result = packFloat(r_s2.sign, 8'h00, '0);
            w_flags  = 4'b0000;
        end else if (r_s2.expAdj <= 0) begin
            w_result = packFloat(r_s2.sign, 8'h00, '0);
            w_flags  = 4'b0011;
        end else if (w_expFinal >= EXP_MAX) begin
            w_result = packFloat(r_s2.sign, 8'hFF, '0);
            w_flags  = 4'b0101;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3Valid <= 1'b0;
            r_result  <= '0;
            r_flags   <= '0;
        end else if (w_advance) begin
            r_s3Valid <= r_s2Valid;
            r_result  <= w_result;
            r_flags   <= w_flags;
        end
    end

endmodule

// File: tb/tb_fpu_normalize_round.sv
// Directed scoreboard bench for fpu_normalize_round: stimulus pushes hand-computed
// results into a queue, an independent monitor pops and compares on each transfer.
module tb_fpu_normalize_round;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [8:0]  in_exp;
    logic [26:0] in_mantissa;
    logic        in_infinite;
    logic        in_invalid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  flags;
        string       name;
    } expect_t;

    expect_t sbQueue[$];
    expect_t monEntry;
    int      errors = 0;
    int      checks = 0;

    fpu_normalize_round #(.ROUND_MODE(ROUND_NEAREST_EVEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_mantissa (in_mantissa),
        .in_infinite (in_infinite),
        .in_invalid  (in_invalid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // A transfer happens at the next rising edge whenever valid and ready are both high
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sbQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedOutput: got %h flags %h, expected none",
                         out_result, out_flags);
            end else begin
                monEntry = sbQueue.pop_front();
                checkOutput({monEntry.name, ".result"}, out_result, monEntry.result);
                checkOutput({monEntry.name, ".flags"}, 32'(out_flags), 32'(monEntry.flags));
            end
        end
    end

    // Entered just after a rising edge; leaves in_valid high so calls can run back to back
    task automatic applyStimulus(input string name, input logic sign, input logic [8:0] e,
                                 input logic [26:0] m, input logic inf, input logic inv,
                                 input logic [31:0] expResult, input logic [3:0] expFlags);
        bit accepted = 0;
        in_valid    = 1'b1;
        in_sign     = sign;
        in_exp      = e;
        in_mantissa = m;
        in_infinite = inf;
        in_invalid  = inv;
        for (int c = 0; c < 20 && !accepted; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                accepted = 1;
                sbQueue.push_back('{expResult, expFlags, name});
            end
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s.acceptTimeout: got in_ready=%b, expected 1", name, in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic goIdle();
        in_valid    = 1'b0;
        in_infinite = 1'b0;
        in_invalid  = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 50 && sbQueue.size() > 0; c++) begin
            @(posedge clk);
        end
        if (sbQueue.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s.drainTimeout: got %0d pending, expected 0", name,
                     sbQueue.size());
            sbQueue.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_sign     = 1'b0;
        in_exp      = '0;
        in_mantissa = '0;
        in_infinite = 1'b0;
        in_invalid  = 1'b0;
        out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetOutValid", 32'(out_valid), 32'd0);
        checkOutput("resetInReady", 32'(in_ready), 32'd1);
        checkOutput("resetResult", out_result, 32'h0);
        checkOutput("resetFlags", 32'(out_flags), 32'd0);
        rst = 1'b0;

        applyStimulus("one",        1'b0, 9'd127, 27'h2000000, 1'b0, 1'b0, 32'h3F800000, 4'b0000);
        applyStimulus("carry",      1'b0, 9'd127, 27'h4000000, 1'b0, 1'b0, 32'h40000000, 4'b0000);
        applyStimulus("rneTieOdd",  1'b0, 9'd127, 27'h2000006, 1'b0, 1'b0, 32'h3F800002, 4'b0001);
        applyStimulus("rneTieEven", 1'b0, 9'd127, 27'h2000002, 1'b0, 1'b0, 32'h3F800000, 4'b0001);
        applyStimulus("rneAbove",   1'b0, 9'd127, 27'h2000003, 1'b0, 1'b0, 32'h3F800001, 4'b0001);
        applyStimulus("roundCarry", 1'b0, 9'd127, 27'h3FFFFFE, 1'b0, 1'b0, 32'h40000000, 4'b0001);
        applyStimulus("carrySticky",1'b0, 9'd127, 27'h4000001, 1'b0, 1'b0, 32'h40000000, 4'b0001);
        applyStimulus("shift23",    1'b0, 9'd150, 27'h0000004, 1'b0, 1'b0, 32'h3F800000, 4'b0000);
        applyStimulus("negative",   1'b1, 9'd128, 27'h2C00000, 1'b0, 1'b0, 32'hC0300000, 4'b0000);
        applyStimulus("overflow",   1'b0, 9'd254, 27'h4000000, 1'b0, 1'b0, 32'h7F800000, 4'b0101);
        applyStimulus("underflow",  1'b0, 9'd1,   27'h1000000, 1'b0, 1'b0, 32'h00000000, 4'b0011);
        applyStimulus("deepUnder",  1'b0, 9'd10,  27'h0000004, 1'b0, 1'b0, 32'h00000000, 4'b0011);
        applyStimulus("invalid",    1'b0, 9'd0,   27'h0000000, 1'b1, 1'b1, 32'h7FC00000, 4'b1000);
        applyStimulus("negZero",    1'b1, 9'd127, 27'h0000000, 1'b0, 1'b0, 32'h80000000, 4'b0000);
        applyStimulus("negInf",     1'b1, 9'd5,   27'h2000000, 1'b1, 1'b0, 32'hFF800000, 4'b0000);
        goIdle();
        drain("directed");

        // Output stalls for two cycles once the first stream result is presented
        fork
            begin
                applyStimulus("stream0", 1'b0, 9'd127, 27'h2000000, 1'b0, 1'b0, 32'h3F800000, 4'b0000);
                applyStimulus("stream1", 1'b0, 9'd128, 27'h2000000, 1'b0, 1'b0, 32'h40000000, 4'b0000);
                applyStimulus("stream2", 1'b0, 9'd129, 27'h2000000, 1'b0, 1'b0, 32'h40800000, 4'b0000);
                applyStimulus("stream3", 1'b0, 9'd130, 27'h2000000, 1'b0, 1'b0, 32'h41000000, 4'b0000);
                applyStimulus("stream4", 1'b0, 9'd131, 27'h2000000, 1'b0, 1'b0, 32'h41800000, 4'b0000);
                goIdle();
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    checkOutput("stallInReady", 32'(in_ready), 32'd0);
                    checkOutput("stallOutValid", 32'(out_valid), 32'd1);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("stall");

        // Reset arrives while later results are still in flight
        applyStimulus("preRst0", 1'b0, 9'd127, 27'h2000000, 1'b0, 1'b0, 32'h3F800000, 4'b0000);
        applyStimulus("preRst1", 1'b1, 9'd128, 27'h2000000, 1'b0, 1'b0, 32'hC0000000, 4'b0000);
        applyStimulus("preRst2", 1'b0, 9'd129, 27'h2000000, 1'b0, 1'b0, 32'h40800000, 4'b0000);
        applyStimulus("preRst3", 1'b0, 9'd130, 27'h2000000, 1'b0, 1'b0, 32'h41000000, 4'b0000);
        rst = 1'b1;
        goIdle();
        sbQueue.delete();
        @(negedge clk);
        checkOutput("rstGateValid", 32'(out_valid), 32'd0);
        checkOutput("rstInReady", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("postRstValid", 32'(out_valid), 32'd0);
        checkOutput("postRstResult", out_result, 32'h0);
        checkOutput("postRstFlags", 32'(out_flags), 32'd0);
        checkOutput("postRstInReady", 32'(in_ready), 32'd1);
        applyStimulus("postRst", 1'b0, 9'd127, 27'h2000000, 1'b0, 1'b0, 32'h3F800000, 4'b0000);
        goIdle();
        drain("postReset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
